// File: rtl/vga_timing_gen.sv
// vga_timing_gen: raster counters, blank/strobe decode and hs/vs delayed to line up with
// the renderer pipeline, plus a free-running frame counter.
module vga_timing_gen #(
    parameter int H_VISIBLE  = 640,
    parameter int H_FRONT    = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BACK     = 48,
    parameter int V_VISIBLE  = 480,
    parameter int V_FRONT    = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BACK     = 33,
    parameter int SYNC_DELAY = 2
) (
    input  logic       vga_clk,
    input  logic       Reset,
    output logic [9:0] DrawX,
    output logic [9:0] DrawY,
    output logic       blank,
    output logic       hs,
    output logic       vs,
    output logic       line_start,
    output logic       frame_start,
    output logic [7:0] frame_count
);
    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam logic [10:0] H_LAST = 11'(H_TOTAL - 1);
    localparam logic [10:0] V_LAST = 11'(V_TOTAL - 1);
    localparam logic [10:0] H_VIS  = 11'(H_VISIBLE);
    localparam logic [10:0] V_VIS  = 11'(V_VISIBLE);
    localparam logic [10:0] HS_ON  = 11'(H_VISIBLE + H_FRONT);
    localparam logic [10:0] HS_OFF = 11'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [10:0] VS_ON  = 11'(V_VISIBLE + V_FRONT);
    localparam logic [10:0] VS_OFF = 11'(V_VISIBLE + V_FRONT + V_SYNC);

    logic [9:0]  hc, vc;
    logic [10:0] hx, vy;
    logic        h_end, h_over, v_end, v_over, hs_raw, vs_raw;

    // 11-bit views so a 1024-count total compares without overflow
    always_comb begin
        hx     = {1'b0, hc};
        vy     = {1'b0, vc};
        h_end  = hx == H_LAST;
        h_over = hx > H_LAST;
        v_end  = vy == V_LAST;
        v_over = vy > V_LAST;
        hs_raw = !(hx >= HS_ON && hx < HS_OFF);
        vs_raw = !(vy >= VS_ON && vy < VS_OFF);
    end

    always_ff @(posedge vga_clk or posedge Reset) begin
        if (Reset) begin
            hc          <= '0;
            vc          <= '0;
            frame_count <= '0;
        end else begin
            hc <= (h_end || h_over) ? '0 : hc + 10'd1;
            vc <= v_over ? '0 : (h_end || h_over) ? (v_end ? '0 : vc + 10'd1) : vc;
            if (h_end && v_end)
                frame_count <= frame_count + 8'd1;
        end
    end

    assign DrawX       = hc;
    assign DrawY       = vc;
    assign blank       = hx < H_VIS && vy < V_VIS;
    assign line_start  = hc == 10'd0;
    assign frame_start = hc == 10'd0 && vc == 10'd0;

    generate
        if (SYNC_DELAY == 0) begin : g_direct
            assign hs = hs_raw;
            assign vs = vs_raw;
        end else begin : g_delay
            logic [SYNC_DELAY-1:0] hs_sr, vs_sr;
            always_ff @(posedge vga_clk or posedge Reset) begin
                if (Reset) begin
                    hs_sr <= '1;
                    vs_sr <= '1;
                end else begin
                    hs_sr <= SYNC_DELAY'({hs_sr, hs_raw});
                    vs_sr <= SYNC_DELAY'({vs_sr, vs_raw});
                end
            end
            assign hs = hs_sr[SYNC_DELAY-1];
            assign vs = vs_sr[SYNC_DELAY-1];
        end
    endgenerate
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: default-timing instance checked over a few lines, and a shrunken
// undelayed instance checked across 256 full frames and a mid-frame reset.
module tb_vga_timing_gen;
    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic       b;
        logic       h;
        logic       v;
        logic       ls;
        logic       fs;
        logic [7:0] f;
    } exp_t;

    typedef struct {
        int   n;
        exp_t e;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_d = 1'b1, rst_s = 1'b1;
    logic [9:0] dx, dy, sx, sy;
    logic       db, dh, dv, dls, dfs, sb, sh, sv, sls, sfs;
    logic [7:0] df, sf;
    int         tests = 0, fails = 0;
    int         nd = 0, ns = 0;
    exp_t       q[$];
    vec_t       dtbl[11];
    vec_t       stbl[3];

    vga_timing_gen dut_d (
        .vga_clk(clk), .Reset(rst_d), .DrawX(dx), .DrawY(dy), .blank(db), .hs(dh), .vs(dv),
        .line_start(dls), .frame_start(dfs), .frame_count(df)
    );

    vga_timing_gen #(
        .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
        .V_VISIBLE(6), .V_FRONT(2), .V_SYNC(2), .V_BACK(3), .SYNC_DELAY(0)
    ) dut_s (
        .vga_clk(clk), .Reset(rst_s), .DrawX(sx), .DrawY(sy), .blank(sb), .hs(sh), .vs(sv),
        .line_start(sls), .frame_start(sfs), .frame_count(sf)
    );

    function automatic exp_t mk(int x, int y, bit b, bit h, bit v, bit ls, bit fs, int f);
        exp_t e;
        e.x = 10'(x); e.y = 10'(y); e.b = b; e.h = h; e.v = v; e.ls = ls; e.fs = fs; e.f = 8'(f);
        return e;
    endfunction

    // closed-form expectation from the number of edges since reset release
    function automatic exp_t model(int n, int hv, int hf, int hw, int hb,
                                   int vv, int vf, int vw, int vb, int dly);
        int ht, vt, x, y, m, mx, my;
        exp_t e;
        ht = hv + hf + hw + hb;
        vt = vv + vf + vw + vb;
        x = n % ht;
        y = (n / ht) % vt;
        e.x = 10'(x);
        e.y = 10'(y);
        e.f = 8'((n / (ht * vt)) % 256);
        e.b = x < hv && y < vv;
        e.ls = x == 0;
        e.fs = x == 0 && y == 0;
        m = n - dly;
        mx = m < 0 ? 0 : m % ht;
        my = m < 0 ? 0 : (m / ht) % vt;
        e.h = m < 0 ? 1'b1 : !(mx >= hv + hf && mx < hv + hf + hw);
        e.v = m < 0 ? 1'b1 : !(my >= vv + vf && my < vv + vf + vw);
        return e;
    endfunction

    function automatic exp_t act_d();
        return {dx, dy, db, dh, dv, dls, dfs, df};
    endfunction

    function automatic exp_t act_s();
        return {sx, sy, sb, sh, sv, sls, sfs, sf};
    endfunction

    task automatic cmp(input string name, input int n, input exp_t a, input exp_t e);
        tests++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s n=%0d got x=%0d y=%0d blank=%b hs=%b vs=%b ls=%b fs=%b fc=%0d want x=%0d y=%0d blank=%b hs=%b vs=%b ls=%b fs=%b fc=%0d",
                     name, n, a.x, a.y, a.b, a.h, a.v, a.ls, a.fs, a.f,
                     e.x, e.y, e.b, e.h, e.v, e.ls, e.fs, e.f);
        end
    endtask

    task automatic run_d(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            nd++;
            q.push_back(model(nd, 640, 16, 96, 48, 480, 10, 2, 33, 2));
            @(negedge clk);
            cmp("d_scan", nd, act_d(), q.pop_front());
            for (int k = 0; k < 11; k++)
                if (dtbl[k].n == nd) cmp("d_vec", nd, act_d(), dtbl[k].e);
        end
    endtask

    task automatic run_s(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            ns++;
            q.push_back(model(ns, 8, 2, 3, 3, 6, 2, 2, 3, 0));
            @(negedge clk);
            cmp("s_scan", ns, act_s(), q.pop_front());
            for (int k = 0; k < 3; k++)
                if (stbl[k].n == ns) cmp("s_vec", ns, act_s(), stbl[k].e);
        end
    endtask

    initial begin
        dtbl[0]  = '{1,    mk(1,   0, 1, 1, 1, 0, 0, 0)};
        dtbl[1]  = '{639,  mk(639, 0, 1, 1, 1, 0, 0, 0)};
        dtbl[2]  = '{640,  mk(640, 0, 0, 1, 1, 0, 0, 0)};
        dtbl[3]  = '{657,  mk(657, 0, 0, 1, 1, 0, 0, 0)};
        dtbl[4]  = '{658,  mk(658, 0, 0, 0, 1, 0, 0, 0)};
        dtbl[5]  = '{753,  mk(753, 0, 0, 0, 1, 0, 0, 0)};
        dtbl[6]  = '{754,  mk(754, 0, 0, 1, 1, 0, 0, 0)};
        dtbl[7]  = '{799,  mk(799, 0, 0, 1, 1, 0, 0, 0)};
        dtbl[8]  = '{800,  mk(0,   1, 1, 1, 1, 1, 0, 0)};
        dtbl[9]  = '{1458, mk(658, 1, 0, 0, 1, 0, 0, 0)};
        dtbl[10] = '{1600, mk(0,   2, 1, 1, 1, 1, 0, 0)};
        stbl[0]  = '{53040, mk(0,  0,  1, 1, 1, 1, 1, 255)};
        stbl[1]  = '{53247, mk(15, 12, 0, 1, 1, 0, 0, 255)};
        stbl[2]  = '{53248, mk(0,  0,  1, 1, 1, 1, 1, 0)};

        repeat (3) @(negedge clk);
        cmp("d_in_reset", 0, act_d(), mk(0, 0, 1, 1, 1, 1, 1, 0));
        rst_d = 1'b0;
        nd = 0;
        run_d(100);
        rst_d = 1'b1;
        #1;
        cmp("d_async_reset", 0, act_d(), mk(0, 0, 1, 1, 1, 1, 1, 0));
        repeat (3) begin
            @(negedge clk);
            cmp("d_reset_hold", 0, act_d(), mk(0, 0, 1, 1, 1, 1, 1, 0));
        end
        rst_d = 1'b0;
        nd = 0;
        run_d(1700);

        rst_s = 1'b0;
        ns = 0;
        run_s(1162);
        cmp("s_mid_frame", ns, act_s(), mk(10, 7, 0, 0, 1, 0, 0, 5));
        rst_s = 1'b1;
        #1;
        cmp("s_async_reset", 0, act_s(), mk(0, 0, 1, 1, 1, 1, 1, 0));
        @(negedge clk);
        cmp("s_reset_hold", 0, act_s(), mk(0, 0, 1, 1, 1, 1, 1, 0));
        rst_s = 1'b0;
        ns = 0;
        run_s(53260);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
